hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (F, D, E, M, W).
- Drives the enable and synchronous-clear inputs of every inter-stage register (F/D, D/E, E/M, M/W) and the PC enable.
- Resolves four hazard types: load-use, taken branch/jump redirect, multi-cycle mul/div occupancy in E, and data-memory wait in M.
- Small FSM plus down-counter; all outputs are combinational from state and inputs.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_luchk.sv | 32 +++
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// +----------------------------------------------------------------------+
// | hazard_pkg: shared types and constants for the hazard sequencer      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MDIV  = 2'd1,
      ST_MWAIT = 2'd2
   } state_t;

   localparam int REG_AW_DEFAULT = 5;

   // Architectural x0: never a real producer, so never a hazard source.
   localparam logic [REG_AW_DEFAULT-1:0] REG_ZERO = '0;

endpackage

`default_nettype wire

// File: rtl/hazard_luchk.sv
// +----------------------------------------------------------------------+
// | hazard_luchk: combinational load-use comparator (E load vs D reads)  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module hazard_luchk
   import hazard_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEFAULT
) (
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic              use_rs1,
   input  logic              use_rs2,
   input  logic [REG_AW-1:0] rd,
   input  logic              load,
   output logic              hazard
);

   logic rd_live;
   logic hit_rs1;
   logic hit_rs2;

   assign rd_live = (rd != REG_AW'(REG_ZERO));
   assign hit_rs1 = use_rs1 && (rs1 == rd);
   assign hit_rs2 = use_rs2 && (rs2 == rd);
   assign hazard  = load && rd_live && (hit_rs1 || hit_rs2);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.         |
// | Optional macro HAZARD_PERF_EN adds stall_cnt / flush_cnt counters.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW   = REG_AW_DEFAULT,
   parameter int MDIV_LAT = 4,
   parameter int CNT_W    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic              use_rs1_d,
   input  logic              use_rs2_d,
   input  logic [REG_AW-1:0] rd_e,
   input  logic              load_e,
   input  logic              redirect_e,
   input  logic              mdiv_start_e,
   input  logic              mem_req_m,
   input  logic              mem_ack_m,
   output logic              en_f,
   output logic              en_d,
   output logic              en_e,
   output logic              en_m,
   output logic              flush_d,
   output logic              flush_e,
   output logic              flush_m,
   output logic              flush_w
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   state_t           state;
   state_t           state_nxt;
   state_t           eff_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             load_use;
   logic             mwait_cond;

   hazard_luchk #(
      .REG_AW (REG_AW)
   ) u_luchk (
      .rs1     (rs1_d),
      .rs2     (rs2_d),
      .use_rs1 (use_rs1_d),
      .use_rs2 (use_rs2_d),
      .rd      (rd_e),
      .load    (load_e),
      .hazard  (load_use)
   );

   assign mwait_cond = mem_req_m && !mem_ack_m;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      en_f      = 1'b1;
      en_d      = 1'b1;
      en_e      = 1'b1;
      en_m      = 1'b1;
      flush_d   = 1'b0;
      flush_e   = 1'b0;
      flush_m   = 1'b0;
      flush_w   = 1'b0;
      state_nxt = state;
      // The divider keeps running regardless of pipeline freezes.
      cnt_nxt   = (cnt != '0) ? (cnt - CNT_W'(1)) : cnt;

      // Once memory completes, behave as the state frozen underneath MWAIT.
      eff_state = state;
      if (state == ST_MWAIT) begin
         eff_state = (cnt != '0) ? ST_MDIV : ST_IDLE;
      end

      if (rst) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else if (mwait_cond) begin
         en_f      = 1'b0;
         en_d      = 1'b0;
         en_e      = 1'b0;
         en_m      = 1'b0;
         flush_w   = 1'b1;
         state_nxt = ST_MWAIT;
      end else begin
         unique case (eff_state)
            ST_MDIV: begin
               en_f      = 1'b0;
               en_d      = 1'b0;
               en_e      = 1'b0;
               flush_m   = 1'b1;
               state_nxt = (cnt <= CNT_W'(1)) ? ST_IDLE : ST_MDIV;
            end
            default: begin
               state_nxt = ST_IDLE;
               if (mdiv_start_e) begin
                  en_f      = 1'b0;
                  en_d      = 1'b0;
                  en_e      = 1'b0;
                  flush_m   = 1'b1;
                  state_nxt = ST_MDIV;
                  cnt_nxt   = CNT_W'(MDIV_LAT - 1);
               end else if (redirect_e) begin
                  flush_d = 1'b1;
                  flush_e = 1'b1;
               end else if (load_use) begin
                  en_f    = 1'b0;
                  en_d    = 1'b0;
                  flush_e = 1'b1;
               end
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!en_f && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (flush_d && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_hazard_ctrl: directed self-checking bench for hazard_ctrl         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hazard_ctrl;

   // Output vector order: {en_f,en_d,en_e,en_m,flush_d,flush_e,flush_m,flush_w}
   localparam logic [7:0] NORM = 8'b1111_0000;
   localparam logic [7:0] LU   = 8'b0011_0100;
   localparam logic [7:0] RED  = 8'b1111_1100;
   localparam logic [7:0] MDV  = 8'b0001_0010;
   localparam logic [7:0] MWT  = 8'b0000_0001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] rs1_d = '0, rs2_d = '0, rd_e = '0;
   logic       use_rs1_d = 0, use_rs2_d = 0, load_e = 0, redirect_e = 0;
   logic       mdiv_start_e = 0, mem_req_m = 0, mem_ack_m = 0;
   logic       en_f, en_d, en_e, en_m, flush_d, flush_e, flush_m, flush_w;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   hazard_ctrl #(
      .REG_AW   (5),
      .MDIV_LAT (4),
      .CNT_W    (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rs1_d        (rs1_d),
      .rs2_d        (rs2_d),
      .use_rs1_d    (use_rs1_d),
      .use_rs2_d    (use_rs2_d),
      .rd_e         (rd_e),
      .load_e       (load_e),
      .redirect_e   (redirect_e),
      .mdiv_start_e (mdiv_start_e),
      .mem_req_m    (mem_req_m),
      .mem_ack_m    (mem_ack_m),
      .en_f         (en_f),
      .en_d         (en_d),
      .en_e         (en_e),
      .en_m         (en_m),
      .flush_d      (flush_d),
      .flush_e      (flush_e),
      .flush_m      (flush_m),
      .flush_w      (flush_w)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // One cycle: drive inputs after the falling edge, check the combinational
   // outputs before the next rising edge.
   task automatic apply(input string tag,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2,
                        input logic [4:0] rd, input logic ld,
                        input logic red, input logic mds,
                        input logic req, input logic ack,
                        input logic [7:0] exp);
      @(negedge clk);
      rs1_d = r1; rs2_d = r2; use_rs1_d = u1; use_rs2_d = u2;
      rd_e = rd; load_e = ld; redirect_e = red; mdiv_start_e = mds;
      mem_req_m = req; mem_ack_m = ack;
      #1;
      chk(tag, {en_f, en_d, en_e, en_m, flush_d, flush_e, flush_m, flush_w}, exp);
   endtask

   initial begin
      // Reset: outputs forced to pass-through even with a hazard on the inputs.
      apply("rst_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      apply("rst_lu",    5, 0, 1, 0, 5, 1, 0, 0, 1, 0, NORM);
      @(negedge clk);
      rst = 1'b0;
      apply("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

      // Load-use
      apply("lu_rs1",    5, 0, 1, 0, 5, 1, 0, 0, 0, 0, LU);
      apply("lu_after",  5, 0, 1, 0, 5, 0, 0, 0, 0, 0, NORM);
      apply("lu_rs2",    1, 7, 1, 1, 7, 1, 0, 0, 0, 0, LU);
      apply("lu_x0",     0, 0, 0, 1, 0, 1, 0, 0, 0, 0, NORM);
      apply("lu_nouse",  5, 0, 0, 0, 5, 1, 0, 0, 0, 0, NORM);
      apply("lu_nomatch",4, 6, 1, 1, 5, 1, 0, 0, 0, 0, NORM);

      // Redirect beats load-use
      apply("red_lu",    5, 0, 1, 0, 5, 1, 1, 0, 0, 0, RED);
      apply("red_only",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, RED);

      // Mul/div with concurrent redirect: 4 frozen cycles, then redirect
      apply("mdiv_0",    0, 0, 0, 0, 0, 0, 1, 1, 0, 0, MDV);
      apply("mdiv_1",    0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MDV);
      apply("mdiv_2",    0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MDV);
      apply("mdiv_3",    0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MDV);
      apply("mdiv_red",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, RED);
      apply("mdiv_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

      // Memory wait, 3 cycles then ack
      apply("mw_0",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MWT);
      apply("mw_1",      5, 0, 1, 0, 5, 1, 1, 0, 1, 0, MWT);
      apply("mw_2",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MWT);
      apply("mw_ack",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NORM);
      apply("mw_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

      // Memory wait inside MDIV: counter keeps running underneath
      apply("mx_start",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MDV);
      apply("mx_w0",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MWT);
      apply("mx_w1",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MWT);
      apply("mx_ack",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, MDV);
      apply("mx_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

      // Asynchronous reset in the middle of MDIV (cnt=2)
      apply("rm_start",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, MDV);
      apply("rm_mdiv",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MDV);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rm_async", {en_f, en_d, en_e, en_m, flush_d, flush_e, flush_m, flush_w}, NORM);
      @(negedge clk);
      rst = 1'b0;
      apply("rm_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
      // A cleared counter means MWAIT exits straight to IDLE.
      apply("rm_mw",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MWT);
      apply("rm_ack",    0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NORM);
      apply("rm_end",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
